// File: rtl/servo_pwm_bank_if.sv
// rtl/servo_pwm_bank_if.sv - decoded local bus between the bus-interface block and servo_pwm_bank
interface servo_pwm_bank_if;
  logic [3:0]  Addr;
  logic [15:0] DataWr;
  logic [15:0] DataRd;
  logic        En;
  logic        Rd;
  logic        Wr;

  modport master (output Addr, DataWr, En, Rd, Wr, input DataRd);
  modport slave  (input Addr, DataWr, En, Rd, Wr, output DataRd);
endinterface

// File: rtl/servo_pwm_bank.sv
// rtl/servo_pwm_bank.sv - bus-attached multi-channel servo PWM generator with frame IRQ
// Optional frame watchdog enabled by defining SERVO_FAILSAFE_EN.
module servo_pwm_bank #(
  parameter int CHANNELS  = 4,
  parameter int PRESCALE  = 50,
  parameter int PERIOD_US = 20000
) (
  input  logic                Clk,
  input  logic                ResetN,
  servo_pwm_bank_if.slave     bus,
  output logic [CHANNELS-1:0] Out,
  output logic                FrameInt
);
  localparam logic [15:0] WIDTH_RESET = 16'd1500;
  localparam logic [15:0] PRE_LAST    = 16'(PRESCALE - 1);
  localparam logic [15:0] FRAME_LAST  = 16'(PERIOD_US - 1);

  logic [15:0]         preCnt;
  logic [15:0]         frameCnt;
  logic [CHANNELS-1:0] ctrlEn;
  logic [CHANNELS-1:0] shadowEn;
  logic                ctrlIrq;
  logic                frameFlag;
  logic                failFlag;
  logic                wrPrev;
  logic [15:0]         width       [CHANNELS];
  logic [15:0]         shadowWidth [CHANNELS];
  logic [15:0]         rdData;

  logic wrAct, commit, tick, boundary, ctrlWr, statusWr, widthWr, wdTrip;
  logic unusedRd;

  assign unusedRd = bus.Rd;
  assign wrAct    = bus.En & bus.Wr;
  // Wr is a level held over a multi-Clk bus cycle; only its first Clk commits.
  assign commit   = wrAct & ~wrPrev;
  assign ctrlWr   = commit && (bus.Addr == 4'h0);
  assign statusWr = commit && (bus.Addr == 4'h1);
  assign widthWr  = commit && bus.Addr[3] && ({1'b0, bus.Addr[2:0]} < 4'(CHANNELS));
  assign tick     = (preCnt == PRE_LAST);
  assign boundary = tick && (frameCnt == FRAME_LAST);

`ifdef SERVO_FAILSAFE_EN
  localparam logic [7:0] WD_LIMIT = 8'd50;
  logic [7:0] wdCnt;

  assign wdTrip = boundary && !widthWr && (wdCnt == WD_LIMIT - 8'd1);

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      wdCnt    <= '0;
      failFlag <= 1'b0;
    end else begin
      if (widthWr) wdCnt <= '0;
      else if (boundary && wdCnt != WD_LIMIT) wdCnt <= wdCnt + 8'd1;
      if (wdTrip) failFlag <= 1'b1;
      else if (statusWr && bus.DataWr[1]) failFlag <= 1'b0;
    end
  end
`else
  assign wdTrip   = 1'b0;
  assign failFlag = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      wrPrev    <= 1'b0;
      preCnt    <= '0;
      frameCnt  <= '0;
      ctrlEn    <= '0;
      ctrlIrq   <= 1'b0;
      frameFlag <= 1'b0;
      shadowEn  <= '0;
      Out       <= '0;
      FrameInt  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        width[i]       <= WIDTH_RESET;
        shadowWidth[i] <= WIDTH_RESET;
      end
    end else begin
      wrPrev <= wrAct;
      preCnt <= tick ? 16'd0 : preCnt + 16'd1;
      if (tick) frameCnt <= boundary ? 16'd0 : frameCnt + 16'd1;

      if (ctrlWr) begin
        ctrlEn  <= bus.DataWr[CHANNELS-1:0];
        ctrlIrq <= bus.DataWr[15];
      end
      if (wdTrip) ctrlEn <= '0;

      for (int i = 0; i < CHANNELS; i++) begin
        if (widthWr && bus.Addr[2:0] == 3'(i)) width[i] <= bus.DataWr;
      end

      // Shadows only move at the frame boundary so a pulse is never cut short.
      if (boundary) begin
        shadowEn <= ctrlEn;
        for (int i = 0; i < CHANNELS; i++) shadowWidth[i] <= width[i];
      end

      if (boundary) frameFlag <= 1'b1;
      else if (statusWr && bus.DataWr[0]) frameFlag <= 1'b0;

      for (int i = 0; i < CHANNELS; i++) begin
        Out[i] <= shadowEn[i] && (frameCnt < shadowWidth[i]);
      end
      FrameInt <= frameFlag & ctrlIrq;
    end
  end

  always_comb begin
    rdData = '0;
    case (bus.Addr)
      4'h0: begin
        rdData[CHANNELS-1:0] = ctrlEn;
        rdData[15]           = ctrlIrq;
      end
      4'h1: rdData[1:0] = {failFlag, frameFlag};
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (bus.Addr == 4'(8 + i)) rdData = width[i];
        end
      end
    endcase
  end

  assign bus.DataRd = rdData;
endmodule
